// File: rtl/ex_stage_mdu.sv
// Execute stage: single-cycle RV32IM-style ALU plus an iterative shift-add multiplier and
// restoring divider, feeding a valid/ready EX/MEM pipeline register.
module ex_stage_mdu #(
    parameter int XLEN       = 32,
    parameter int CTRL_MEM_W = 5,
    parameter int RD_W       = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_op,
    input  logic                  use_imm,
    input  logic [CTRL_MEM_W-1:0] ctrl_mem_in,
    input  logic [RD_W-1:0]       rd_in,
    input  logic [XLEN-1:0]       rs1_val,
    input  logic [XLEN-1:0]       rs2_val,
    input  logic [XLEN-1:0]       imm,
    input  logic [XLEN-1:0]       pc4_in,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_MEM_W-1:0] ctrl_mem_out,
    output logic [RD_W-1:0]       rd_out,
    output logic [XLEN-1:0]       alu_result,
    output logic [XLEN-1:0]       store_data,
    output logic [XLEN-1:0]       pc4_out
);
    localparam int SH_W  = $clog2(XLEN);
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIV   = 4'd12;
    localparam logic [3:0] OP_DIVU  = 4'd13;
    localparam logic [3:0] OP_REM   = 4'd14;

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t state, state_next;
    logic [CNT_W-1:0] cnt;

    logic free, accept, is_mdu_in, wr_alu, wr_mdu;
    logic [XLEN-1:0] opb, alu_res;
    logic [SH_W-1:0] shamt;
    logic signed [XLEN-1:0] a_s, b_s;

    logic sdiv_in, neg_a_in, neg_b_in;
    logic [XLEN-1:0] a_abs, b_abs;

    // Latched multi-cycle operation: hi/lo double as product halves or remainder/quotient
    logic [3:0]            op_p0;
    logic [XLEN-1:0]       hi_p0, lo_p0, opnd_p0, dividend_p0;
    logic                  neg_q_p0, neg_r_p0, div_zero_p0;
    logic [CTRL_MEM_W-1:0] ctrl_p0;
    logic [RD_W-1:0]       rd_p0;
    logic [XLEN-1:0]       store_p0, pc4_p0;

    logic                  is_mul_p0;
    logic [XLEN:0]         mul_sum;
    logic [XLEN:0]         div_shift;
    logic [XLEN+1:0]       div_diff;
    logic [XLEN-1:0]       hi_next, lo_next;

    // Undo operand pre-negation and apply the divide-by-zero results.
    function automatic logic [XLEN-1:0] mdu_result(
        input logic [3:0]      op,
        input logic [XLEN-1:0] hi,
        input logic [XLEN-1:0] lo,
        input logic [XLEN-1:0] dividend,
        input logic            neg_q,
        input logic            neg_r,
        input logic            div_zero
    );
        logic [XLEN-1:0] res;
        case (op)
            OP_MUL:          res = lo;
            OP_MULHU:        res = hi;
            OP_DIV, OP_DIVU: res = div_zero ? '1 : (neg_q ? -lo : lo);
            default:         res = div_zero ? dividend : (neg_r ? -hi : hi);
        endcase
        return res;
    endfunction

    assign opb       = use_imm ? imm : rs2_val;
    assign shamt     = opb[SH_W-1:0];
    assign a_s       = $signed(rs1_val);
    assign b_s       = $signed(opb);
    assign free      = !out_valid || out_ready;
    assign in_ready  = (state == IDLE) && free && !flush;
    assign accept    = in_valid && in_ready;
    assign is_mdu_in = (alu_op >= OP_MUL);
    assign wr_alu    = accept && !is_mdu_in;
    assign wr_mdu    = (state == HOLD) && free && !flush;

    assign sdiv_in  = (alu_op == OP_DIV) || (alu_op == OP_REM);
    assign neg_a_in = sdiv_in && rs1_val[XLEN-1];
    assign neg_b_in = sdiv_in && opb[XLEN-1];
    assign a_abs    = neg_a_in ? -rs1_val : rs1_val;
    assign b_abs    = neg_b_in ? -opb : opb;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = rs1_val + opb;
            OP_SUB:  alu_res = rs1_val - opb;
            OP_AND:  alu_res = rs1_val & opb;
            OP_OR:   alu_res = rs1_val | opb;
            OP_XOR:  alu_res = rs1_val ^ opb;
            OP_SLL:  alu_res = rs1_val << shamt;
            OP_SRL:  alu_res = rs1_val >> shamt;
            OP_SRA:  alu_res = a_s >>> shamt;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (rs1_val < opb)};
            default: alu_res = '0;
        endcase
    end

    // One shift-add or restoring-divide step per BUSY cycle
    assign is_mul_p0 = (op_p0 == OP_MUL) || (op_p0 == OP_MULHU);
    assign mul_sum   = {1'b0, hi_p0} + (lo_p0[0] ? {1'b0, opnd_p0} : '0);
    assign div_shift = {hi_p0, lo_p0[XLEN-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b0, opnd_p0};

    always_comb begin
        hi_next = hi_p0;
        lo_next = lo_p0;
        if (is_mul_p0) begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo_p0[XLEN-1:1]};
        end else if (!div_diff[XLEN+1]) begin
            hi_next = div_diff[XLEN-1:0];
            lo_next = {lo_p0[XLEN-2:0], 1'b1};
        end else begin
            hi_next = div_shift[XLEN-1:0];
            lo_next = {lo_p0[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (accept)
                cnt <= '0;
            else if (state == BUSY)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && is_mdu_in) state_next = BUSY;
            BUSY: begin
                if (flush)
                    state_next = IDLE;
                else if (cnt == CNT_W'(XLEN-1))
                    state_next = HOLD;
            end
            HOLD: if (flush || free) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_p0       <= alu_op;
            hi_p0       <= '0;
            lo_p0       <= is_mdu_in && (alu_op >= OP_DIV) ? a_abs : opb;
            opnd_p0     <= is_mdu_in && (alu_op >= OP_DIV) ? b_abs : rs1_val;
            dividend_p0 <= rs1_val;
            neg_q_p0    <= neg_a_in ^ neg_b_in;
            neg_r_p0    <= neg_a_in;
            div_zero_p0 <= (opb == '0);
            ctrl_p0     <= ctrl_mem_in;
            rd_p0       <= rd_in;
            store_p0    <= rs2_val;
            pc4_p0      <= pc4_in;
        end else if (state == BUSY) begin
            hi_p0 <= hi_next;
            lo_p0 <= lo_next;
        end
    end

    // EX/MEM register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid    <= 1'b0;
            ctrl_mem_out <= '0;
            rd_out       <= '0;
            alu_result   <= '0;
            store_data   <= '0;
            pc4_out      <= '0;
        end else begin
            if (wr_alu) begin
                ctrl_mem_out <= ctrl_mem_in;
                rd_out       <= rd_in;
                alu_result   <= alu_res;
                store_data   <= rs2_val;
                pc4_out      <= pc4_in;
            end else if (wr_mdu) begin
                ctrl_mem_out <= ctrl_p0;
                rd_out       <= rd_p0;
                alu_result   <= mdu_result(op_p0, hi_p0, lo_p0, dividend_p0,
                                           neg_q_p0, neg_r_p0, div_zero_p0);
                store_data   <= store_p0;
                pc4_out      <= pc4_p0;
            end
            if (wr_alu || wr_mdu)
                out_valid <= 1'b1;
            else if (out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed and randomized bench for ex_stage_mdu (XLEN=32) against a plain-arithmetic model.
module tb_ex_stage_mdu;
    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic        use_imm;
    logic [4:0]  ctrl_mem_in;
    logic [4:0]  rd_in;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [31:0] pc4_in;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  ctrl_mem_out;
    logic [4:0]  rd_out;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [31:0] pc4_out;

    int n_cmp;
    int n_fail;
    logic [31:0] last_exp;

    ex_stage_mdu #(.XLEN(32), .CTRL_MEM_W(5), .RD_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .use_imm(use_imm), .ctrl_mem_in(ctrl_mem_in), .rd_in(rd_in),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc4_in(pc4_in), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .ctrl_mem_out(ctrl_mem_out),
        .rd_out(rd_out), .alu_result(alu_result), .store_data(store_data), .pc4_out(pc4_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference results straight from the RV32IM arithmetic definitions.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] p;
        logic [4:0]  sh;
        sh = b[4:0];
        p  = 64'(a) * 64'(b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << sh;
            4'd6:  return a >> sh;
            4'd7:  return 32'($signed(a) >>> sh);
            4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'($signed(a) / $signed(b));
            end
            4'd13: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            4'd14: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'($signed(a) % $signed(b));
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op with out_ready=1 and check everything it writes; called #1 after an edge.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic ui, input logic [31:0] im,
                          input logic [31:0] exp);
        logic [4:0]  rd, cm;
        logic [31:0] pc;
        int lat, rdy_hi;
        rd = 5'($urandom_range(0, 31));
        cm = 5'($urandom_range(0, 31));
        pc = $urandom;
        alu_op = op; rs1_val = a; rs2_val = b; use_imm = ui; imm = im;
        rd_in = rd; ctrl_mem_in = cm; pc4_in = pc; out_ready = 1'b1; in_valid = 1'b1;
        #1;
        lat = 0;
        while (!in_ready && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        rdy_hi = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) rdy_hi++;
            @(posedge clk); #1; lat++;
        end
        check({tag, "_latency"}, 32'(lat), (op >= 4'd10) ? 32'd33 : 32'd0);
        check({tag, "_busy_ready"}, 32'(rdy_hi), 32'd0);
        check({tag, "_result"}, alu_result, exp);
        check({tag, "_rd"}, 32'(rd_out), 32'(rd));
        check({tag, "_ctrl"}, 32'(ctrl_mem_out), 32'(cm));
        check({tag, "_store"}, store_data, b);
        check({tag, "_pc4"}, pc4_out, pc);
        last_exp = exp;
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b, im, held, cnt_hi;
        logic        ui;
        n_cmp = 0; n_fail = 0; last_exp = '0;
        reset_n = 1'b0; in_valid = 1'b0; alu_op = '0; use_imm = 1'b0; ctrl_mem_in = '0;
        rd_in = '0; rs1_val = '0; rs2_val = '0; imm = '0; pc4_in = '0; flush = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", alu_result, 32'd0);
        check("reset_pc4", pc4_out, 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_imm", 4'd0, 32'd7, 32'h1234_5678, 1'b1, 32'hFFFF_FFFD, 32'd4);
        run_op("sra", 4'd7, 32'h8000_0000, 32'h24, 1'b0, 32'd0, 32'hF800_0000);
        run_op("srl", 4'd6, 32'h8000_0000, 32'h24, 1'b0, 32'd0, 32'h0800_0000);
        run_op("sltu", 4'd9, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd1);
        run_op("slt", 4'd8, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0);
        run_op("mul", 4'd10, 32'h1_0000, 32'h1_0000, 1'b0, 32'd0, 32'd0);
        run_op("mulhu", 4'd11, 32'h1_0000, 32'h1_0000, 1'b0, 32'd0, 32'd1);
        run_op("div_neg", 4'd12, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 32'hFFFF_FFFD);
        run_op("rem_neg", 4'd14, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 32'hFFFF_FFFF);
        run_op("divu_zero", 4'd13, 32'd5, 32'd0, 1'b0, 32'd0, 32'hFFFF_FFFF);
        run_op("remu_zero", 4'd15, 32'd5, 32'd0, 1'b0, 32'd0, 32'd5);
        run_op("div_ovf", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
        run_op("rem_ovf", 4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0);
        run_op("div_zero_s", 4'd12, 32'hFFFF_FFFB, 32'd0, 1'b0, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_zero_s", 4'd14, 32'hFFFF_FFFB, 32'd0, 1'b0, 32'd0, 32'hFFFF_FFFB);

        // Backpressure: result held, new ADD waits, then is written as the old one leaves
        held = last_exp;
        out_ready = 1'b0;
        alu_op = 4'd0; rs1_val = 32'd100; rs2_val = 32'd23; use_imm = 1'b0; in_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_result", alu_result, held);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_new_valid", 32'(out_valid), 32'd1);
        check("bp_new_result", alu_result, 32'd123);

        // Flush while idle: no accept, EX/MEM contents untouched
        alu_op = 4'd1; rs1_val = 32'd9; rs2_val = 32'd4; flush = 1'b1; in_valid = 1'b1;
        #1;
        check("flush_idle_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle_valid", 32'(out_valid), 32'd0);
        check("flush_idle_result", alu_result, 32'd123);

        // Flush ten cycles into a DIVU
        alu_op = 4'd13; rs1_val = 32'd1000; rs2_val = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        check("flush_busy_ready", 32'(in_ready), 32'd1);
        check("flush_busy_valid", 32'(out_valid), 32'd0);
        cnt_hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) cnt_hi++;
        end
        check("flush_no_result", cnt_hi, 32'd0);

        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom; b = $urandom; im = $urandom;
            ui = (op < 4'd10) ? 1'($urandom_range(0, 1)) : 1'b0;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: b = $urandom_range(1, 40);
                default: ;
            endcase
            run_op("random", op, a, b, ui, im, ref_alu(op, a, ui ? im : b));
        end

        // Asynchronous reset in the middle of a MUL
        run_op("pre_reset_add", 4'd0, 32'd5, 32'd6, 1'b0, 32'd0, 32'd11);
        alu_op = 4'd10; rs1_val = 32'd3; rs2_val = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", alu_result, 32'd0);
        check("rst_store", store_data, 32'd0);
        check("rst_rd", 32'(rd_out), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        cnt_hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) cnt_hi++;
        end
        check("rst_discarded", cnt_hi, 32'd0);
        run_op("post_reset_mul", 4'd10, 32'd3, 32'd4, 1'b0, 32'd0, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
